// File: rtl/pc_fetch_unit.sv
// PC register + instruction fetch: fetches imem[pc] over req/ack and presents it to decode over valid/ready.
// Latency: reset release -> imem_req 1 cycle; ack -> ir_valid next cycle; decode accept -> next imem_req next cycle.
// Backpressure: ir_ready low holds ir_out/pc stable in HOLD with no new fetch; missing ack for TIMEOUT cycles latches fault.
module pc_fetch_unit #(
  parameter int          AW       = 10,
  parameter int          DW       = 32,
  parameter int          OFFW     = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int          TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] next_pc_in,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [DW-1:0] ir_out,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_1_out,
  output logic [AW-1:0] bra_out,
  output logic          fault
);

  // Counter must be able to count up to TIMEOUT.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;

  logic [AW-1:0] offset_sext;

  // State and datapath registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and handshake outputs; ack/ready are only honoured in their own state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    imem_req = 1'b0;
    ir_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // Ack wins even on the cycle the timeout would otherwise fire.
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // This edge is the TIMEOUT-th one without an ack.
          cnt_d   = CW'(TIMEOUT);
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        ir_valid = 1'b1;
        if (ir_ready) begin
          pc_d    = next_pc_in;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FAULT: begin
        // Sticky until reset.
        fault_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Branch offset sign-extended from its top bit.
  always_comb begin
    offset_sext = {{(AW-OFFW){ir_q[OFFW-1]}}, ir_q[OFFW-1:0]};
  end

  // Candidate addresses for the next-address mux; wrap modulo 2^AW.
  always_comb begin
    pc_1_out = pc_q + AW'(1);
    bra_out  = pc_q + AW'(1) + offset_sext;
  end

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign fault     = fault_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage on the far side of the next-address select logic.
- Holds the PC register and fetches the instruction at PC from instruction memory over a req/ack handshake.
- Presents the instruction to decode over a valid/ready handshake.
- Produces the PC+1 and branch-target candidates consumed by the next-address mux, then loads the mux's selected address as the new PC.

Parameters:
- AW, 10, PC / instruction-memory address width.
- DW, 32, instruction width.
- OFFW, 8, width of signed branch offset field, taken from ir_out[OFFW-1:0].
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 15, max cycles to wait for imem_ack before flagging fault.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- next_pc_in  input  AW  next address selected by next-address mux; sampled only on the decode handshake.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  AW  fetch address; equals pc.
- imem_ack  input  1  memory response; imem_rdata valid in the same cycle.
- imem_rdata  input  DW  instruction word.
- ir_valid  output  1  ir_out holds a valid instruction.
- ir_ready  input  1  decode accepts ir_out.
- ir_out  output  DW  instruction register.
- pc_out  output  AW  current PC.
- pc_1_out  output  AW  pc+1 mod 2^AW; combinational from pc.
- bra_out  output  AW  pc+1+sext(ir_out[OFFW-1:0]) mod 2^AW; combinational.
- fault  output  1  sticky fetch-timeout flag.

Behaviour:
- State machine: IDLE, FETCH, HOLD, FAULT; state is registered.
- Reset (sampled high at an edge):
  - state←IDLE, pc←RESET_PC, ir_out←0, wait counter←0, fault←0.
  - imem_req=0 and ir_valid=0 while in IDLE.
  - Reset overrides every other input in the same cycle.
  - Reset mid-fetch abandons the request; imem_req is low the cycle after.
- IDLE: on the first edge with reset low, go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On an edge with imem_ack=1: ir_out←imem_rdata, counter←0, go to HOLD.
  - Otherwise the counter increments; when counter==TIMEOUT with no ack, fault←1 and go to FAULT.
  - An ack arriving on the same edge the counter reaches TIMEOUT is accepted (ack wins).
- HOLD:
  - imem_req=0, ir_valid=1; ir_out and pc stay stable.
  - On an edge with ir_ready=1: pc←next_pc_in, go to FETCH.
  - ir_ready while ir_valid=0 is ignored.
- FAULT:
  - imem_req=0, ir_valid=0, fault=1. Exit only via reset.
- imem_ack outside FETCH is ignored; ir_out is not modified.
- Latency:
  - Reset deassert to first imem_req: 1 cycle (IDLE→FETCH).
  - ack edge to ir_valid: ir_valid high from the next cycle.
  - Decode accept to the next imem_req: next cycle.
  - Minimum throughput: 1 instruction per 2 cycles.
- Arithmetic:
  - pc_1_out and bra_out are truncated to AW bits, so they wrap: pc=1023 gives pc_1_out=0.
  - The offset is sign-extended from bit OFFW-1.
  - pc_1_out and bra_out are driven in all states, but are meaningful to consumers only while ir_valid=1.
- pc_out=pc always; imem_addr=pc always; imem_req gates its use.

Test Plan:
- Reset then release; memory acks on the 1st request cycle with 0x0000_0003.
  - imem_req rises 1 cycle after release with imem_addr=0.
  - Next cycle: ir_valid=1, ir_out=0x00000003, pc_1_out=1, bra_out=4.
- In HOLD with pc=5, ir_out[7:0]=0xFE; ir_ready=1 with next_pc_in=bra_out.
  - bra_out=4.
  - Next cycle: pc=4, imem_req=1, imem_addr=4.
- Back-pressure: hold ir_ready=0 for 6 cycles in HOLD.
  - ir_valid stays 1; ir_out and pc unchanged; imem_req stays 0.
  - Assert ir_ready: pc←next_pc_in.
- Wrap: RESET_PC=1023; ir_out[7:0]=0x01.
  - pc_1_out=0, bra_out=1.
- Timeout: no ack for 15 cycles in FETCH.
  - fault=1, imem_req=0, ir_valid=0.
  - fault holds until reset; the same check with ack on exactly the 15th cycle gives HOLD and fault=0.
- Reset asserted mid-FETCH (req high, no ack); ack arrives the cycle after.
  - imem_req=0, ack ignored, ir_valid=0, pc=RESET_PC.
